climate_scheduler: RTL and testbench
====================================

CLIMATE_SCHEDULER -- requirements
Module: climate_scheduler

Interface
REQ-001 Parameter PERIOD_TICKS, default 100_000_000, is the number of clk cycles between sensor reads (1 s at 100 MHz).
REQ-002 Parameter TIMEOUT_TICKS, default 50_000_000, is the maximum number of clk cycles to wait for a DHT11 result.
REQ-003 Parameters TEMP_ON/TEMP_OFF, defaults 28/26 (degrees C), are the fan hysteresis thresholds.
REQ-004 Parameters HUM_ON/HUM_OFF, defaults 40/45 (%RH), are the humidifier hysteresis thresholds.
REQ-005 Parameter FAULT_LIMIT, default 3, is the number of consecutive failed reads that declares a sensor fault.
REQ-006 Ports: clk in 1 (100 MHz system clock); rst_n in 1 (reset); dht_start out 1 (read-trigger pulse); dht_done in 1 (result-valid pulse); dht_err in 1 (checksum/protocol error pulse); dht_temp in 8; dht_hum in 8.
REQ-007 Ports: uart_req out 1; uart_ack in 1; lcd_req out 1; lcd_ack in 1; temp_out out 8; hum_out out 8; fan_on out 1; humid_on out 1; sensor_fault out 1; err_cnt out 8 (saturating count of failed reads).
REQ-008 The block SHALL use one clock, clk; reset rst_n SHALL be synchronous and active-low.

Function
REQ-009 The period counter SHALL count 0..PERIOD_TICKS-1 and wrap, and SHALL emit a one-cycle tick at the terminal count regardless of FSM state.
REQ-010 A tick arriving outside IDLE SHALL set a one-deep pending flag; additional ticks while the flag is already set SHALL be dropped.
REQ-011 The FSM states SHALL be IDLE, START, WAIT, UPDATE, NOTIFY.
REQ-012 IDLE SHALL go to START on a tick or a set pending flag, clearing the flag.
REQ-013 START SHALL assert dht_start for exactly one cycle and SHALL then go to WAIT with the timeout counter cleared.
REQ-014 In WAIT, dht_err SHALL take priority over dht_done, and dht_done SHALL take priority over a timeout occurring in the same cycle.
REQ-015 A dht_done accepted in WAIT SHALL be range-checked; the read is valid only if dht_temp<=50 and 20<=dht_hum<=90.
REQ-016 A valid read sampled at edge E SHALL be staged and SHALL move the FSM to UPDATE.
REQ-017 At edge E+1, temp_out/hum_out, fan_on/humid_on and uart_req/lcd_req SHALL all update together, and the FSM SHALL enter NOTIFY.
REQ-018 Fan hysteresis: fan_on SHALL set when temp>=TEMP_ON, clear when temp<=TEMP_OFF, and hold otherwise; humid_on SHALL set when hum<=HUM_ON, clear when hum>=HUM_OFF, and hold otherwise.
REQ-019 A failed read (err, timeout after TIMEOUT_TICKS cycles in WAIT, or out of range) SHALL increment err_cnt (saturating at 255) and the consecutive-fail counter, SHALL leave data outputs unchanged, and SHALL return to IDLE without requests.
REQ-020 When the consecutive-fail count reaches FAULT_LIMIT, sensor_fault SHALL set, fan_on/humid_on SHALL force to 0, and a single NOTIFY round SHALL be issued.
REQ-021 A valid read SHALL clear the consecutive-fail count and sensor_fault.
REQ-022 In NOTIFY, uart_req and lcd_req SHALL each stay high until their own ack is sampled high, then drop the next edge; the FSM SHALL return to IDLE when both are low.
REQ-023 An ack received while its req is low SHALL be ignored, and an ack in the same cycle as req rises SHALL be sampled on the following edge.

Reset
REQ-024 While rst_n=0 at a clk edge, all outputs SHALL be 0, the FSM SHALL be IDLE, all counters and the pending flag SHALL be 0, and no dht_start pulse SHALL be emitted.
REQ-025 Reset asserted mid-WAIT or mid-NOTIFY SHALL abort the transaction, and a late dht_done or ack after reset SHALL be ignored in IDLE.

Structure
REQ-026 State encodings, the DHT11 range limits (0..50 C, 20..90 %RH) and the threshold defaults SHALL live in the shared package coldstorage_pkg.
REQ-027 The period counter with its tick and pending flag SHALL be a sub-module named period_tick; all other logic SHALL be in climate_scheduler.

Verification (PERIOD_TICKS=100, TIMEOUT_TICKS=20)
REQ-028 Reset release, dht_done 5 cycles after dht_start with temp=25, hum=50 -> temp_out=25, hum_out=50, fan_on=0, humid_on=0, both reqs high 1 cycle after done.
REQ-029 Successive reads with temp 27,28,27,26 -> fan_on 0,1,1,0; successive reads with hum 41,40,44,45 -> humid_on 0,1,1,0.
REQ-030 No response for 3 periods -> err_cnt=3, sensor_fault=1 with a single req pair, fan_on=0; next valid read -> sensor_fault=0.
REQ-031 dht_done and dht_err in the same cycle -> treated as error, outputs held; temp=60 -> rejected, err_cnt+1.
REQ-032 lcd_ack held off 250 cycles -> two ticks pending-collapsed, exactly one dht_start issued right after NOTIFY exits.
REQ-033 rst_n low during WAIT, then dht_done -> no output change, next dht_start exactly 100 cycles after reset release.

Source files
------------

// File: rtl/coldstorage_pkg.sv
// Shared constants for the cold-storage climate scheduler: FSM encodings,
// DHT11 valid measurement window and default hysteresis thresholds.
package coldstorage_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_UPDATE = 3'd3;
   localparam logic [2:0] ST_NOTIFY = 3'd4;

   // DHT11 window is 0..50 C and 20..90 %RH; the 0 C floor is implicit in the unsigned byte.
   localparam logic [7:0] DHT_TEMP_MAX = 8'd50;
   localparam logic [7:0] DHT_HUM_MIN  = 8'd20;
   localparam logic [7:0] DHT_HUM_MAX  = 8'd90;

   localparam int unsigned TEMP_ON_DEFAULT  = 28;
   localparam int unsigned TEMP_OFF_DEFAULT = 26;
   localparam int unsigned HUM_ON_DEFAULT   = 40;
   localparam int unsigned HUM_OFF_DEFAULT  = 45;

   function automatic logic dht_in_range(input logic [7:0] temp, input logic [7:0] hum);
      return (temp <= DHT_TEMP_MAX) && (hum >= DHT_HUM_MIN) && (hum <= DHT_HUM_MAX);
   endfunction

   function automatic logic hyst_next(input logic cur, input logic set_c, input logic clr_c);
      if (set_c) return 1'b1;
      if (clr_c) return 1'b0;
      return cur;
   endfunction

endpackage

// File: rtl/period_tick.sv
// Free-running sensor period counter with a one-deep pending flag that
// remembers a tick which arrived while the scheduler was busy.
module period_tick #(
   parameter int unsigned PERIOD_TICKS = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic idle_i,
   output logic tick_o,
   output logic pending_o
);

   localparam int unsigned CW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
   localparam logic [CW-1:0] TERM = CW'(PERIOD_TICKS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pending_q, pending_d;

   assign tick_o    = (cnt_q == TERM);
   assign pending_o = pending_q;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      cnt_d     = tick_o ? '0 : cnt_q + CW'(1);
      pending_d = pending_q;
      // IDLE always consumes a pending tick, so the flag only lives outside IDLE.
      if (idle_i)      pending_d = 1'b0;
      else if (tick_o) pending_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous (sampled on the clock edge) and state uses non-blocking assignments.
      if (!rst_n) begin
         cnt_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/climate_scheduler.sv
// Periodic DHT11 read scheduler: range-checks results, drives fan/humidifier
// with hysteresis, tracks read failures and hands results to UART and LCD.
module climate_scheduler
   import coldstorage_pkg::*;
#(
   parameter int unsigned PERIOD_TICKS  = 100_000_000,
   parameter int unsigned TIMEOUT_TICKS = 50_000_000,
   parameter int unsigned TEMP_ON       = TEMP_ON_DEFAULT,
   parameter int unsigned TEMP_OFF      = TEMP_OFF_DEFAULT,
   parameter int unsigned HUM_ON        = HUM_ON_DEFAULT,
   parameter int unsigned HUM_OFF       = HUM_OFF_DEFAULT,
   parameter int unsigned FAULT_LIMIT   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       dht_start,
   input  logic       dht_done,
   input  logic       dht_err,
   input  logic [7:0] dht_temp,
   input  logic [7:0] dht_hum,
   output logic       uart_req,
   input  logic       uart_ack,
   output logic       lcd_req,
   input  logic       lcd_ack,
   output logic [7:0] temp_out,
   output logic [7:0] hum_out,
   output logic       fan_on,
   output logic       humid_on,
   output logic       sensor_fault,
   output logic [7:0] err_cnt
);

   localparam int unsigned TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
   localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_TICKS - 1);
   localparam logic [7:0] TEMP_ON_B  = 8'(TEMP_ON);
   localparam logic [7:0] TEMP_OFF_B = 8'(TEMP_OFF);
   localparam logic [7:0] HUM_ON_B   = 8'(HUM_ON);
   localparam logic [7:0] HUM_OFF_B  = 8'(HUM_OFF);
   localparam logic [7:0] FAULT_B    = 8'(FAULT_LIMIT);

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]    stage_t_q, stage_t_d, stage_h_q, stage_h_d;
   logic [7:0]    temp_q, temp_d, hum_q, hum_d;
   logic          fan_q, fan_d, humid_q, humid_d, fault_q, fault_d;
   logic [7:0]    err_cnt_q, err_cnt_d, fail_q, fail_d;
   logic          uart_q, uart_d, lcd_q, lcd_d;
   logic          tick, pending, fail;

   period_tick #(.PERIOD_TICKS(PERIOD_TICKS)) u_period_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .idle_i    (state_q == ST_IDLE),
      .tick_o    (tick),
      .pending_o (pending)
   );

   always_comb begin
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      stage_t_d = stage_t_q;
      stage_h_d = stage_h_q;
      temp_d    = temp_q;
      hum_d     = hum_q;
      fan_d     = fan_q;
      humid_d   = humid_q;
      fault_d   = fault_q;
      err_cnt_d = err_cnt_q;
      fail_d    = fail_q;
      uart_d    = uart_q;
      lcd_d     = lcd_q;
      fail      = 1'b0;

      case (state_q)
         ST_IDLE: if (tick || pending) state_d = ST_START;
         ST_START: begin
            to_cnt_d = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            to_cnt_d = to_cnt_q + TW'(1);
            if (dht_err) begin
               fail = 1'b1;
            end else if (dht_done) begin
               if (dht_in_range(dht_temp, dht_hum)) begin
                  stage_t_d = dht_temp;
                  stage_h_d = dht_hum;
                  state_d   = ST_UPDATE;
               end else begin
                  fail = 1'b1;
               end
            end else if (to_cnt_q == TO_TERM) begin
               fail = 1'b1;
            end
         end
         ST_UPDATE: begin
            temp_d  = stage_t_q;
            hum_d   = stage_h_q;
            fan_d   = hyst_next(fan_q, stage_t_q >= TEMP_ON_B, stage_t_q <= TEMP_OFF_B);
            humid_d = hyst_next(humid_q, stage_h_q <= HUM_ON_B, stage_h_q >= HUM_OFF_B);
            fail_d  = '0;
            fault_d = 1'b0;
            uart_d  = 1'b1;
            lcd_d   = 1'b1;
            state_d = ST_NOTIFY;
         end
         ST_NOTIFY: begin
            if (uart_q && uart_ack) uart_d = 1'b0;
            if (lcd_q && lcd_ack)   lcd_d  = 1'b0;
            if (!uart_q && !lcd_q)  state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Only the failure that reaches the limit announces the fault; later ones stay silent.
      if (fail) begin
         err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
         fail_d    = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;
         state_d   = ST_IDLE;
         if ((fail_q != 8'hFF) && (fail_q + 8'd1 == FAULT_B)) begin
            fault_d = 1'b1;
            fan_d   = 1'b0;
            humid_d = 1'b0;
            uart_d  = 1'b1;
            lcd_d   = 1'b1;
            state_d = ST_NOTIFY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         to_cnt_q  <= '0;
         stage_t_q <= '0;
         stage_h_q <= '0;
         temp_q    <= '0;
         hum_q     <= '0;
         fan_q     <= 1'b0;
         humid_q   <= 1'b0;
         fault_q   <= 1'b0;
         err_cnt_q <= '0;
         fail_q    <= '0;
         uart_q    <= 1'b0;
         lcd_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         stage_t_q <= stage_t_d;
         stage_h_q <= stage_h_d;
         temp_q    <= temp_d;
         hum_q     <= hum_d;
         fan_q     <= fan_d;
         humid_q   <= humid_d;
         fault_q   <= fault_d;
         err_cnt_q <= err_cnt_d;
         fail_q    <= fail_d;
         uart_q    <= uart_d;
         lcd_q     <= lcd_d;
      end
   end

   assign dht_start    = (state_q == ST_START);
   assign uart_req     = uart_q;
   assign lcd_req      = lcd_q;
   assign temp_out     = temp_q;
   assign hum_out      = hum_q;
   assign fan_on       = fan_q;
   assign humid_on     = humid_q;
   assign sensor_fault = fault_q;
   assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_climate_scheduler.sv
// Directed self-checking bench for climate_scheduler with a short period
// (100 cycles) and timeout (20 cycles).
module tb_climate_scheduler;

   localparam int PERIOD  = 100;
   localparam int TIMEOUT = 20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dht_start, dht_done, dht_err;
   logic [7:0] dht_temp, dht_hum;
   logic       uart_req, uart_ack, lcd_req, lcd_ack;
   logic [7:0] temp_out, hum_out, err_cnt;
   logic       fan_on, humid_on, sensor_fault;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   climate_scheduler #(.PERIOD_TICKS(PERIOD), .TIMEOUT_TICKS(TIMEOUT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dht_start    (dht_start),
      .dht_done     (dht_done),
      .dht_err      (dht_err),
      .dht_temp     (dht_temp),
      .dht_hum      (dht_hum),
      .uart_req     (uart_req),
      .uart_ack     (uart_ack),
      .lcd_req      (lcd_req),
      .lcd_ack      (lcd_ack),
      .temp_out     (temp_out),
      .hum_out      (hum_out),
      .fan_on       (fan_on),
      .humid_on     (humid_on),
      .sensor_fault (sensor_fault),
      .err_cnt      (err_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int budget, output int n, output bit found);
      n = 0;
      found = 1'b0;
      while (!found && n < budget) begin
         step();
         n++;
         if (dht_start) found = 1'b1;
      end
   endtask

   // Waits for dht_start, answers 5 cycles later; returns 1ns after the sampling edge.
   task automatic read(input string tag, input logic [7:0] t, input logic [7:0] h, input logic e);
      int n;
      bit found;
      wait_start(300, n, found);
      check({tag, "_start_seen"}, found, 1);
      repeat (4) step();
      dht_temp = t;
      dht_hum  = h;
      dht_done = 1'b1;
      dht_err  = e;
      step();
      dht_done = 1'b0;
      dht_err  = 1'b0;
   endtask

   task automatic ack_both();
      uart_ack = 1'b1;
      lcd_ack  = 1'b1;
      step();
      uart_ack = 1'b0;
      lcd_ack  = 1'b0;
      step();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dht_start"}, dht_start, 0);
      check({tag, "_uart_req"}, uart_req, 0);
      check({tag, "_lcd_req"}, lcd_req, 0);
      check({tag, "_temp_out"}, temp_out, 0);
      check({tag, "_hum_out"}, hum_out, 0);
      check({tag, "_fan_humid"}, {fan_on, humid_on}, 0);
      check({tag, "_fault"}, sensor_fault, 0);
      check({tag, "_err_cnt"}, err_cnt, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] temps [8] = '{8'd27, 8'd28, 8'd27, 8'd26, 8'd25, 8'd25, 8'd25, 8'd25};
      logic [7:0] hums  [8] = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd41, 8'd40, 8'd44, 8'd45};
      logic       exp_fan [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       exp_hum [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int  n, cnt;
      bit  found;

      dht_done = 1'b0; dht_err = 1'b0; dht_temp = '0; dht_hum = '0;
      uart_ack = 1'b0; lcd_ack = 1'b0;
      repeat (3) step();
      check_all_zero("reset");
      rst_n = 1'b1;

      // First read: start exactly one period after reset release, then temp 25 / hum 50.
      wait_start(300, n, found);
      check("first_start_latency", n, PERIOD);
      repeat (4) step();
      dht_temp = 8'd25; dht_hum = 8'd50; dht_done = 1'b1;
      step();
      dht_done = 1'b0;
      check("req_not_yet_at_done_edge", {uart_req, lcd_req}, 2'b00);
      step();
      check("r1_temp", temp_out, 25);
      check("r1_hum", hum_out, 50);
      check("r1_fan_humid", {fan_on, humid_on}, 2'b00);
      check("r1_reqs", {uart_req, lcd_req}, 2'b11);
      uart_ack = 1'b1;
      step();
      uart_ack = 1'b0;
      check("r1_uart_dropped_lcd_held", {uart_req, lcd_req}, 2'b01);
      lcd_ack = 1'b1;
      step();
      lcd_ack = 1'b0;
      check("r1_lcd_dropped", {uart_req, lcd_req}, 2'b00);

      // Hysteresis sequences.
      for (int i = 0; i < 8; i++) begin
         read($sformatf("hyst%0d", i), temps[i], hums[i], 1'b0);
         step();
         check($sformatf("hyst%0d_fan", i), fan_on, exp_fan[i]);
         check($sformatf("hyst%0d_humid", i), humid_on, exp_hum[i]);
         ack_both();
      end

      read("hot_dry", 8'd30, 8'd30, 1'b0);
      step();
      check("hot_dry_fan_humid", {fan_on, humid_on}, 2'b11);
      ack_both();

      // Three silent periods -> fault on the third timeout.
      for (int i = 0; i < 3; i++) begin
         wait_start(300, n, found);
         check($sformatf("to%0d_start_seen", i), found, 1);
         repeat (30) step();
         check($sformatf("to%0d_err_cnt", i), err_cnt, i + 1);
         if (i < 2) begin
            check($sformatf("to%0d_no_fault", i), sensor_fault, 0);
            check($sformatf("to%0d_no_req", i), {uart_req, lcd_req}, 2'b00);
         end
      end
      check("fault_set", sensor_fault, 1);
      check("fault_reqs", {uart_req, lcd_req}, 2'b11);
      check("fault_forced_off", {fan_on, humid_on}, 2'b00);
      check("fault_temp_held", temp_out, 30);
      ack_both();
      repeat (10) step();
      check("fault_single_round", {uart_req, lcd_req}, 2'b00);

      read("recover", 8'd27, 8'd42, 1'b0);
      step();
      check("recover_fault_clear", sensor_fault, 0);
      check("recover_temp", temp_out, 27);
      check("recover_fan_humid_hold", {fan_on, humid_on}, 2'b00);
      ack_both();

      // Error beats done; out-of-range values are rejected.
      read("err_and_done", 8'd10, 8'd60, 1'b1);
      step();
      check("err_and_done_cnt", err_cnt, 4);
      check("err_and_done_temp_held", temp_out, 27);
      check("err_and_done_no_req", {uart_req, lcd_req}, 2'b00);
      read("temp60", 8'd60, 8'd50, 1'b0);
      step();
      check("temp60_cnt", err_cnt, 5);
      check("temp60_temp_held", temp_out, 27);
      read("edge_valid", 8'd50, 8'd90, 1'b0);
      step();
      check("edge_valid_temp", temp_out, 50);
      check("edge_valid_hum", hum_out, 90);
      check("edge_valid_fan_humid", {fan_on, humid_on}, 2'b10);
      ack_both();
      read("hum19", 8'd20, 8'd19, 1'b0);
      step();
      check("hum19_cnt", err_cnt, 6);
      check("hum19_hum_held", hum_out, 90);

      // Held-off LCD ack: ticks collapse into a single pending start.
      read("holdoff", 8'd25, 8'd50, 1'b0);
      step();
      uart_ack = 1'b1;
      step();
      uart_ack = 1'b0;
      cnt = 0;
      repeat (250) begin
         step();
         if (dht_start) cnt++;
      end
      check("holdoff_no_start_in_notify", cnt, 0);
      check("holdoff_lcd_still_req", lcd_req, 1);
      lcd_ack = 1'b1;
      step();
      lcd_ack = 1'b0;
      wait_start(10, n, found);
      check("holdoff_pending_start", found, 1);
      cnt = 0;
      repeat (30) begin
         step();
         if (dht_start) cnt++;
      end
      check("holdoff_only_one_start", cnt, 0);
      check("holdoff_timeout_cnt", err_cnt, 7);

      // Reset mid-WAIT, then a late done and acks must be ignored.
      wait_start(300, n, found);
      check("rst_start_seen", found, 1);
      repeat (3) step();
      rst_n = 1'b0;
      repeat (2) step();
      check_all_zero("midwait_reset");
      rst_n = 1'b1;
      dht_temp = 8'd33; dht_hum = 8'd55; dht_done = 1'b1;
      uart_ack = 1'b1; lcd_ack = 1'b1;
      n = 0;
      found = 1'b0;
      while (!found && n < 200) begin
         step();
         n++;
         if (n == 1) begin
            dht_done = 1'b0; uart_ack = 1'b0; lcd_ack = 1'b0;
         end
         if (dht_start) found = 1'b1;
      end
      check("post_reset_start_latency", n, PERIOD);
      check("post_reset_temp", temp_out, 0);
      check("post_reset_reqs", {uart_req, lcd_req}, 2'b00);
      check("post_reset_err_cnt", err_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
